symbol_draw_sched: RTL
======================

# symbol_draw_sched

Round-robin scheduler that shares one symbol-drawing engine and the VGA adapter write port between up to NREQ requesters, such as board cells each wanting a sprite drawn. It latches the winning requester's base coordinates, sequences the engine's enable, generates the adapter's plot strobe, and returns a completion pulse to the requester. It sits between game/board logic and the drawing engine plus VGA adapter.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WD_LIMIT, 55, cycles in DRAW before the watchdog fires (engine pixel count 51 + margin)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester; held until its done pulse
- req_x  in  8*NREQ  base x per requester, slice i = [8i+7:8i]
- req_y  in  7*NREQ  base y per requester, slice i = [7i+6:7i]
- grant  out  NREQ  one-hot, the requester currently being served
- done  out  NREQ  one-cycle completion pulse to the served requester
- draw_in  out  1  enable/count-run to drawing engine; low holds engine counter cleared
- draw_x  out  8  latched base x to engine
- draw_y  out  7  latched base y to engine
- draw_next  in  1  engine end-of-symbol indication
- plot  out  1  VGA adapter write enable
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky watchdog flag (tied 0 when SCHED_WATCHDOG_EN is undefined)

## Operation
- States: IDLE, LOAD, DRAW, DONE.
- IDLE: if any req bit is set, select the first set bit searching upward, with wrap, from ptr+1. Latch req_x/req_y slices into draw_x/draw_y, set grant, go to LOAD. Otherwise stay.
- LOAD: one cycle with draw_in=0 so engine coordinates settle from cleared counter. Go to DRAW.
- DRAW: draw_in=1. Exit to DONE on the cycle draw_next is sampled high, or on a watchdog expiry.
- DONE: draw_in=0, done[granted]=1 for this cycle only, ptr <= granted index. Go to IDLE; grant clears on entry to IDLE.
- plot = draw_in registered one cycle, matching the engine's registered coordinate output. It is therefore high from the 2nd DRAW cycle through the DONE cycle.
- A req deasserting while granted is ignored; the draw completes and done still pulses.
- New/changed req or req_x/req_y while busy has no effect until the next IDLE.
- Minimum inter-draw gap: 1 IDLE cycle, so the same requester cannot be re-granted without passing through IDLE.
- Reset (any time, including mid-DRAW) values:
  - state=IDLE, ptr=NREQ-1 (so requester 0 wins first)
  - grant=0, done=0, draw_in=0, plot=0, busy=0, err=0
  - draw_x=0, draw_y=0

## Timing
- req sampled high at edge t (IDLE) gives grant, draw_x/draw_y and busy valid after t.
- Cycle sequence from that edge: LOAD at t+1, DRAW from t+2, plot from t+3.
- DRAW with draw_next sampled high at edge d gives DONE for one cycle (done pulse, plot still 1), then IDLE with plot=0.
- Total occupancy for a 51-pixel engine ending at draw_next: LOAD 1 + DRAW n + DONE 1 cycles. n is set by the engine.
- Simultaneous requests are served one per grant in rotating order. No requester waits more than NREQ-1 other draws.
- The watchdog counter is 6 bits. It clears on DRAW entry, increments each DRAW cycle, and saturates.

## Configuration
- Macro: SCHED_WATCHDOG_EN.
- Defined:
  - If the DRAW count reaches WD_LIMIT with no draw_next, the block takes the DONE path: done pulses normally and err sets.
  - err stays set until reset.
- Undefined:
  - No counter is built. DRAW waits indefinitely for draw_next.
  - err is constant 0.

## Test plan
- Single requester: req=4'b0010, req_x[15:8]=8'd40, req_y[13:7]=7'd20, engine asserts draw_next after 51 DRAW cycles -> grant=0010, draw_x=40, draw_y=20, 51 plot cycles, done=0010 for one cycle, busy low after.
- Simultaneous requests: req=4'b1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, each separated by DONE then IDLE.
- Withdrawal: requester 2 drops req mid-DRAW -> draw completes, done[2] pulses, next grant goes to another set request.
- Reset mid-DRAW: reset_n low for 2 cycles at DRAW cycle 10 -> all outputs 0 immediately. After release with req=0001, grant=0001 on the first IDLE edge.
- Watchdog (macro defined): draw_next tied 0 -> DONE after 55 DRAW cycles, done pulses, err=1 and stays 1 across later draws until reset. With the macro undefined, busy stays 1 indefinitely.
- Back-to-back same requester: only req[3] held continuously -> re-granted after exactly one IDLE cycle, with done pulses every (n+3) cycles.

Source files
------------

// File: rtl/symbol_draw_sched.sv
// symbol_draw_sched: round-robin scheduler that shares one symbol engine and the VGA write port
// between NREQ requesters. Optional DRAW watchdog is built when SCHED_WATCHDOG_EN is defined.
module symbol_draw_sched #(
    parameter int NREQ     = 4,
    parameter int WD_LIMIT = 55
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_x,
    input  logic [7*NREQ-1:0] req_y,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              draw_in,
    output logic [7:0]        draw_x,
    output logic [6:0]        draw_y,
    input  logic              draw_next,
    output logic              plot,
    output logic              busy,
    output logic              err
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || WD_LIMIT < 1 || WD_LIMIT > 63) begin : g_cfg_check
        $error("symbol_draw_sched: NREQ must be 2..8 and WD_LIMIT 1..63");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] gidx;
    logic [IDXW-1:0] win_idx;
    logic            win_vld;
    logic [NREQ-1:0] win_oh;
    logic [7:0]      win_x;
    logic [6:0]      win_y;
    logic            wd_fire;

    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NREQ) s = s - NREQ;
        return IDXW'(s);
    endfunction

    // Search upward from the last served requester so every waiting requester is reached
    // within NREQ-1 other grants.
    always_comb begin
        logic [IDXW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = wrap_idx(ptr, k);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_oh = '0;
        win_x  = '0;
        win_y  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                win_oh[i] = win_vld;
                win_x     = req_x[8*i +: 8];
                win_y     = req_y[7*i +: 7];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        draw_in   = 1'b0;
        busy      = 1'b1;
        done      = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_vld) state_nxt = LOAD;
            end
            // Engine counter stays cleared for one cycle so its coordinates settle.
            LOAD: state_nxt = DRAW;
            DRAW: begin
                draw_in = 1'b1;
                if (draw_next || wd_fire) state_nxt = DONE;
            end
            DONE: begin
                done      = grant;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // plot lags draw_in by one cycle to line up with the engine's registered pixel output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant  <= '0;
            gidx   <= '0;
            ptr    <= IDXW'(NREQ - 1);
            draw_x <= '0;
            draw_y <= '0;
            plot   <= 1'b0;
        end else begin
            plot <= draw_in;
            if (state == IDLE && win_vld) begin
                grant  <= win_oh;
                gidx   <= win_idx;
                draw_x <= win_x;
                draw_y <= win_y;
            end
            if (state == DONE) begin
                grant <= '0;
                ptr   <= gidx;
            end
        end
    end

`ifdef SCHED_WATCHDOG_EN
    logic [5:0] wd_cnt;
    logic       err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == LOAD) begin
                wd_cnt <= '0;
            end else if (state == DRAW && wd_cnt != 6'h3f) begin
                wd_cnt <= wd_cnt + 6'd1;
            end
            if (wd_fire && !draw_next) err_q <= 1'b1;
        end
    end

    // Fires on the WD_LIMIT-th DRAW cycle, so DONE follows exactly WD_LIMIT DRAW cycles.
    assign wd_fire = (state == DRAW) && (wd_cnt == 6'(WD_LIMIT - 1));
    assign err     = err_q;
`else
    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
